// File: rtl/oled_pkg.sv
// Shared constants and types for the 96x64 OLED sprite mover.
package oled_pkg;

  localparam int SCR_W = 96;
  localparam int SCR_H = 64;

  // RGB565 colours
  localparam logic [15:0] COL_BLACK  = 16'h0000;
  localparam logic [15:0] COL_GREEN  = 16'h07E0;
  localparam logic [15:0] COL_RED    = 16'hF800;
  localparam logic [15:0] COL_ORANGE = 16'hFBE0;

  // Sprite direction, one-hot
  typedef enum logic [4:0] {
    DIR_IDLE  = 5'b00001,
    DIR_UP    = 5'b00010,
    DIR_DOWN  = 5'b00100,
    DIR_LEFT  = 5'b01000,
    DIR_RIGHT = 5'b10000
  } dir_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational overlap test of two rectangles with inclusive bounds.
// A point test is a rectangle whose x0==x1 and y0==y1.
module rect_overlap #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a_x0,
  input  logic [W-1:0] i_a_x1,
  input  logic [W-1:0] i_a_y0,
  input  logic [W-1:0] i_a_y1,
  input  logic [W-1:0] i_b_x0,
  input  logic [W-1:0] i_b_x1,
  input  logic [W-1:0] i_b_y0,
  input  logic [W-1:0] i_b_y1,
  output logic         o_hit
);

  assign o_hit = (i_a_x0 <= i_b_x1) && (i_b_x0 <= i_a_x1) &&
                 (i_a_y0 <= i_b_y1) && (i_b_y0 <= i_a_y1);

endmodule

// File: rtl/sprite_mover_ctrl.sv
// Button-driven sprite mover with edge/obstacle blocking and a registered
// pixel renderer for the OLED pixel_index/pixel_data interface.
//
//   state     | meaning
//   DIR_IDLE  | sprite at rest
//   DIR_UP    | stepping towards row 0
//   DIR_DOWN  | stepping towards the bottom row
//   DIR_LEFT  | stepping towards column 0
//   DIR_RIGHT | stepping towards the right column
module sprite_mover_ctrl
  import oled_pkg::*;
#(
  parameter int          X_SIZE       = SCR_W,
  parameter int          Y_SIZE       = SCR_H,
  parameter int          SPR_SIZE     = 7,
  parameter int          START_X      = 4,
  parameter int          START_Y      = 4,
  parameter int          OBS_X0       = 35,
  parameter int          OBS_X1       = 60,
  parameter int          OBS_Y0       = 20,
  parameter int          OBS_Y1       = 45,
  parameter int          STEP_DIV     = 1,
  parameter int          WRAP         = 0,
  parameter logic [15:0] COL_SPRITE   = COL_GREEN,
  parameter logic [15:0] COL_OBS_IDLE = COL_RED,
  parameter logic [15:0] COL_OBS_MOVE = COL_ORANGE
) (
  input  logic        clksig,
  input  logic        rst_n,
  input  logic [4:0]  btn,
  input  logic [12:0] pixel_index,
  output logic [15:0] pixel_data,
  output logic [6:0]  sprite_x,
  output logic [5:0]  sprite_y,
  output logic        moving,
  output logic        blocked
);

  localparam logic [7:0]  X_MAX     = 8'(X_SIZE - SPR_SIZE);
  localparam logic [7:0]  Y_MAX     = 8'(Y_SIZE - SPR_SIZE);
  localparam logic [7:0]  SPR_EXT   = 8'(SPR_SIZE - 1);
  localparam int          CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [12:0] PIX_TOTAL = 13'(X_SIZE * Y_SIZE);

  dir_t             r_dir, w_dir_nxt;
  logic [6:0]       r_x;
  logic [5:0]       r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_blocked;
  logic [15:0]      r_pix;

  logic [7:0]  w_x8, w_y8, w_cx, w_cy;
  logic        w_tick, w_step, w_edge, w_obs_hit, w_legal, w_refuse, w_clr;
  logic [7:0]  w_px, w_py;
  logic        w_spr_pt, w_obs_pt;
  logic [15:0] w_pix_nxt;

  // All position arithmetic at 8 bits so pos+SPR_SIZE-1 and pos-1 cannot alias
  assign w_x8   = {1'b0, r_x};
  assign w_y8   = {2'b00, r_y};
  assign w_tick = (r_cnt == CNT_LAST);
  assign w_step = w_tick && (r_dir != DIR_IDLE);

  // Candidate position one pixel along the registered direction
  always_comb begin
    w_cx   = w_x8;
    w_cy   = w_y8;
    w_edge = 1'b0;
    case (r_dir)
      DIR_UP:
        if (w_y8 == 8'd0) begin w_edge = 1'b1; w_cy = Y_MAX; end
        else w_cy = w_y8 - 8'd1;
      DIR_DOWN:
        if (w_y8 >= Y_MAX) begin w_edge = 1'b1; w_cy = 8'd0; end
        else w_cy = w_y8 + 8'd1;
      DIR_LEFT:
        if (w_x8 == 8'd0) begin w_edge = 1'b1; w_cx = X_MAX; end
        else w_cx = w_x8 - 8'd1;
      DIR_RIGHT:
        if (w_x8 >= X_MAX) begin w_edge = 1'b1; w_cx = 8'd0; end
        else w_cx = w_x8 + 8'd1;
      default: ;
    endcase
  end

  rect_overlap #(.W(8)) u_obs_chk (
    .i_a_x0 (w_cx),
    .i_a_x1 (w_cx + SPR_EXT),
    .i_a_y0 (w_cy),
    .i_a_y1 (w_cy + SPR_EXT),
    .i_b_x0 (8'(OBS_X0)),
    .i_b_x1 (8'(OBS_X1)),
    .i_b_y0 (8'(OBS_Y0)),
    .i_b_y1 (8'(OBS_Y1)),
    .o_hit  (w_obs_hit)
  );

  // With wrap enabled an edge crossing is legal; the wrapped spot is still obstacle-checked
  assign w_legal  = (!w_edge || (WRAP != 0)) && !w_obs_hit;
  assign w_refuse = w_step && !w_legal;

  // Direction next-state: buttons win over a refused step, centre only when no direction pressed
  always_comb begin
    w_dir_nxt = r_dir;
    if (btn[1])        w_dir_nxt = DIR_UP;
    else if (btn[4])   w_dir_nxt = DIR_DOWN;
    else if (btn[2])   w_dir_nxt = DIR_LEFT;
    else if (btn[3])   w_dir_nxt = DIR_RIGHT;
    else if (btn[0])   w_dir_nxt = DIR_IDLE;
    else if (w_refuse) w_dir_nxt = DIR_IDLE;
  end

  // A button only restarts the step period when it actually changes direction
  assign w_clr = (|btn) && (w_dir_nxt != r_dir);

  // Direction state register
  always_ff @(posedge clksig or negedge rst_n) begin
    if (!rst_n) r_dir <= DIR_IDLE;
    else        r_dir <= w_dir_nxt;
  end

  // Step-rate counter
  always_ff @(posedge clksig or negedge rst_n) begin
    if (!rst_n)               r_cnt <= '0;
    else if (w_clr || w_tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Sprite position and refused-step pulse
  always_ff @(posedge clksig or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= 7'(START_X);
      r_y       <= 6'(START_Y);
      r_blocked <= 1'b0;
    end else begin
      r_blocked <= w_refuse;
      if (w_step && w_legal) begin
        r_x <= w_cx[6:0];
        r_y <= w_cy[5:0];
      end
    end
  end

  assign w_px = 8'(pixel_index % 13'(X_SIZE));
  assign w_py = 8'(pixel_index / 13'(X_SIZE));

  rect_overlap #(.W(8)) u_spr_pt (
    .i_a_x0 (w_px),
    .i_a_x1 (w_px),
    .i_a_y0 (w_py),
    .i_a_y1 (w_py),
    .i_b_x0 (w_x8),
    .i_b_x1 (w_x8 + SPR_EXT),
    .i_b_y0 (w_y8),
    .i_b_y1 (w_y8 + SPR_EXT),
    .o_hit  (w_spr_pt)
  );

  rect_overlap #(.W(8)) u_obs_pt (
    .i_a_x0 (w_px),
    .i_a_x1 (w_px),
    .i_a_y0 (w_py),
    .i_a_y1 (w_py),
    .i_b_x0 (8'(OBS_X0)),
    .i_b_x1 (8'(OBS_X1)),
    .i_b_y0 (8'(OBS_Y0)),
    .i_b_y1 (8'(OBS_Y1)),
    .o_hit  (w_obs_pt)
  );

  // Pixel colour: sprite over obstacle over background; off-panel indices are black
  always_comb begin
    w_pix_nxt = 16'h0000;
    if (pixel_index < PIX_TOTAL) begin
      if (w_spr_pt)      w_pix_nxt = COL_SPRITE;
      else if (w_obs_pt) w_pix_nxt = (r_dir != DIR_IDLE) ? COL_OBS_MOVE : COL_OBS_IDLE;
    end
  end

  // Registered pixel output
  always_ff @(posedge clksig or negedge rst_n) begin
    if (!rst_n) r_pix <= 16'h0000;
    else        r_pix <= w_pix_nxt;
  end

  assign pixel_data = r_pix;
  assign sprite_x   = r_x;
  assign sprite_y   = r_y;
  assign moving     = (r_dir != DIR_IDLE);
  assign blocked    = r_blocked;

endmodule

// File: tb/tb_sprite_mover_ctrl.sv
// Bench for sprite_mover_ctrl: two configurations run side by side against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_sprite_mover_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  btn_a, btn_b;
  logic [12:0] pix_a, pix_b;
  logic [15:0] pd_a, pd_b;
  logic [6:0]  sx_a, sx_b;
  logic [5:0]  sy_a, sy_b;
  logic        mv_a, mv_b, bl_a, bl_b;
  logic        chk_en;

  sprite_mover_ctrl u_a (
    .clksig(clk), .rst_n(rst_n), .btn(btn_a), .pixel_index(pix_a),
    .pixel_data(pd_a), .sprite_x(sx_a), .sprite_y(sy_a), .moving(mv_a), .blocked(bl_a)
  );

  sprite_mover_ctrl #(.START_Y(25), .STEP_DIV(4), .WRAP(1)) u_b (
    .clksig(clk), .rst_n(rst_n), .btn(btn_b), .pixel_index(pix_b),
    .pixel_data(pd_b), .sprite_x(sx_b), .sprite_y(sy_b), .moving(mv_b), .blocked(bl_b)
  );

  // dir: 0 idle, 1 up, 2 down, 3 left, 4 right
  typedef struct packed {
    int x; int y; int dir; int cnt; int blk; int pix;
  } mst_t;

  mst_t m_a, m_b;
  int n_vec = 0;
  int n_err = 0;

  function automatic int render(int idx, mst_t s);
    int px, py;
    if (idx >= 96 * 64) return 0;
    px = idx % 96;
    py = idx / 96;
    if (px >= s.x && px <= s.x + 6 && py >= s.y && py <= s.y + 6) return 'h07E0;
    if (px >= 35 && px <= 60 && py >= 20 && py <= 45) return (s.dir != 0) ? 'hFBE0 : 'hF800;
    return 0;
  endfunction

  function automatic bit hits_obs(int x, int y);
    return !(x + 6 < 35 || x > 60 || y + 6 < 20 || y > 45);
  endfunction

  function automatic mst_t step(mst_t s, logic [4:0] b, int idx, int sd, bit wrap);
    mst_t n;
    int dx, dy, cx, cy, want;
    bit ok, refuse;
    n = s;
    dx = 0; dy = 0; refuse = 0;
    n.pix = render(idx, s);
    if (s.cnt == sd - 1 && s.dir != 0) begin
      case (s.dir)
        1: dy = -1;
        2: dy = 1;
        3: dx = -1;
        default: dx = 1;
      endcase
      cx = s.x + dx;
      cy = s.y + dy;
      ok = 1;
      if (cx < 0 || cx > 89 || cy < 0 || cy > 57) begin
        if (wrap) begin
          if (cx < 0) cx = 89; else if (cx > 89) cx = 0;
          if (cy < 0) cy = 57; else if (cy > 57) cy = 0;
        end else ok = 0;
      end
      if (ok && hits_obs(cx, cy)) ok = 0;
      if (ok) begin n.x = cx; n.y = cy; end
      else refuse = 1;
    end
    want = -1;
    if (b[1]) want = 1;
    else if (b[4]) want = 2;
    else if (b[2]) want = 3;
    else if (b[3]) want = 4;
    else if (b[0]) want = 0;
    if (want >= 0) n.dir = want;
    else if (refuse) n.dir = 0;
    if (want >= 0 && want != s.dir) n.cnt = 0;
    else n.cnt = (s.cnt == sd - 1) ? 0 : s.cnt + 1;
    n.blk = refuse ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic [15:0] pd, input logic [6:0] sx,
                          input logic [5:0] sy, input logic mv, input logic bl, input mst_t m);
    check({tag, "_x"}, 32'(sx), m.x);
    check({tag, "_y"}, 32'(sy), m.y);
    check({tag, "_moving"}, 32'(mv), (m.dir != 0) ? 1 : 0);
    check({tag, "_blocked"}, 32'(bl), m.blk);
    check({tag, "_pixel"}, 32'(pd), m.pix);
  endtask

  // Reference model advance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '{x: 4, y: 4,  dir: 0, cnt: 0, blk: 0, pix: 0};
      m_b <= '{x: 4, y: 25, dir: 0, cnt: 0, blk: 0, pix: 0};
    end else begin
      m_a <= step(m_a, btn_a, int'(pix_a), 1, 1'b0);
      m_b <= step(m_b, btn_b, int'(pix_b), 4, 1'b1);
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("a", pd_a, sx_a, sy_a, mv_a, bl_a, m_a);
      cmp_inst("b", pd_b, sx_b, sy_b, mv_b, bl_b, m_b);
    end
  end

  function automatic logic [4:0] rnd_btn();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return 5'b0;
    if (r < 92) return 5'(1 << $urandom_range(1, 4));
    if (r < 96) return 5'b00001;
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [12:0] rnd_pix(int sx, int sy);
    if ($urandom_range(0, 9) < 3)
      return 13'((sy + $urandom_range(0, 6)) * 96 + sx + $urandom_range(0, 6));
    return 13'($urandom_range(0, 8191));
  endfunction

  int got, blk, seen0;

  initial begin
    rst_n = 1'b0; btn_a = '0; btn_b = '0; pix_a = '0; pix_b = '0; chk_en = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_a_x", 32'(sx_a), 4);
    check("rst_a_y", 32'(sy_a), 4);
    check("rst_a_moving", 32'(mv_a), 0);
    check("rst_a_pixel0", 32'(pd_a), 0);
    check("rst_b_y", 32'(sy_b), 25);

    // A: render probe at (4,4) moving right, then run to the right edge
    @(negedge clk); #2 btn_a = 5'b01000;
    @(posedge clk); #1 btn_a = '0; pix_a = 13'(4 * 96 + 4);
    @(posedge clk); #1;
    check("probe_sprite", 32'(pd_a), 'h07E0);
    check("a_x_first_step", 32'(sx_a), 5);
    pix_a = 13'(20 * 96 + 35);
    @(posedge clk); #1;
    check("probe_obs_moving", 32'(pd_a), 'hFBE0);
    pix_a = '0;
    @(posedge clk); #1;
    check("probe_background", 32'(pd_a), 0);
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(posedge clk); #1;
      if (bl_a) got = 1;
    end
    check("a_edge_blocked_seen", got, 1);
    check("a_edge_stop_x", 32'(sx_a), 89);
    check("a_edge_moving", 32'(mv_a), 0);
    @(posedge clk); #1;
    check("a_blocked_one_cycle", 32'(bl_a), 0);

    // B: hold right into the obstacle
    @(negedge clk); #2 btn_b = 5'b01000;
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(posedge clk); #1;
      if (bl_b) got = 1;
    end
    check("b_obs_blocked_seen", got, 1);
    check("b_obs_stop_x", 32'(sx_b), 28);
    check("b_held_moving", 32'(mv_b), 1);
    @(negedge clk); #2 btn_b = 5'b00001;
    @(posedge clk); #1 btn_b = '0; pix_b = 13'(20 * 96 + 35);
    @(posedge clk); #1;
    check("b_obs_idle_colour", 32'(pd_b), 'hF800);
    check("b_idle_moving", 32'(mv_b), 0);

    // B: step divider, moving down once every 4 cycles
    @(negedge clk); #2 btn_b = 5'b10000;
    @(posedge clk); #1 btn_b = '0;
    repeat (3) @(posedge clk); #1;
    check("b_y_before_tick", 32'(sy_b), 25);
    @(posedge clk); #1;
    check("b_y_tick1", 32'(sy_b), 26);
    repeat (4) @(posedge clk); #1;
    check("b_y_tick2", 32'(sy_b), 27);
    btn_b = 5'b00001;
    @(posedge clk); #1 btn_b = '0;
    repeat (10) @(posedge clk); #1;
    check("b_y_centre_hold", 32'(sy_b), 27);

    // B: wrap from column 0 to the right edge
    @(negedge clk); #2 btn_b = 5'b00100;
    @(posedge clk); #1 btn_b = '0;
    got = 0; blk = 0; seen0 = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      @(posedge clk); #1;
      if (bl_b) blk = 1;
      if (sx_b == 7'd0) seen0 = 1;
      else if (seen0 != 0) got = 1;
    end
    check("b_wrap_reached", got, 1);
    check("b_wrap_x", 32'(sx_b), 89);
    check("b_wrap_no_block", blk, 0);
    @(negedge clk); #2 btn_b = 5'b00001;
    @(posedge clk); #1 btn_b = '0;

    // Random phase with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      btn_a = rnd_btn();
      btn_b = rnd_btn();
      pix_a = rnd_pix(m_a.x, m_a.y);
      pix_b = rnd_pix(m_b.x, m_b.y);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
